// File: rtl/spike_event_encoder.sv
// Spike-event encoder: captures a timestep spike vector and serializes each set
// bit into a single-cycle event, spaced so the receiver always returns to IDLE.
// Optional build macro ROUND_ROBIN_EN: rotating-priority index selection with a
// pointer that persists across frames; undefined gives lowest-index-first.
module spike_event_encoder #(
  parameter int unsigned N_NEURONS  = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned GAP_CYCLES = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_NEURONS-1:0] spike_vec,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  output logic [ADDR_W-1:0]    event_addr,
  output logic                 event_received,
  output logic                 frame_done,
  output logic                 spike_overflow
);

  localparam int unsigned CNT_W = $clog2(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, EMIT, HOLD} state_t;

  state_t               state, state_next;
  logic [N_NEURONS-1:0] pending, pending_next, src;
  logic [CNT_W-1:0]     gap_cnt, gap_cnt_next;
  logic [ADDR_W-1:0]    sel_idx, addr_next;
  logic                 received_next, done_next, ready_next, overflow_next;

  // Selection source: the fresh vector when starting a frame, else what is left
  assign src = (state == IDLE) ? spike_vec : pending;

`ifdef ROUND_ROBIN_EN
  logic [ADDR_W-1:0] rr_ptr;

  // First set bit at or above rr_ptr, wrapping modulo N_NEURONS
  always_comb begin
    int unsigned j;
    logic        found;
    sel_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N_NEURONS; k++) begin
      j = 32'(rr_ptr) + k;
      if (j >= N_NEURONS) j = j - N_NEURONS;
      if (!found && src[ADDR_W'(j)]) begin
        sel_idx = ADDR_W'(j);
        found   = 1'b1;
      end
    end
  end

  // Advance the fairness pointer past each emitted index
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (received_next) begin
      rr_ptr <= (sel_idx == ADDR_W'(N_NEURONS - 1)) ? '0 : sel_idx + ADDR_W'(1);
    end
  end
`else
  // Fixed priority: lowest set bit wins
  always_comb begin
    sel_idx = '0;
    for (int i = int'(N_NEURONS) - 1; i >= 0; i--) begin
      if (src[i]) sel_idx = ADDR_W'(i);
    end
  end
`endif

  // Next-state and registered-output values
  always_comb begin
    state_next    = state;
    pending_next  = pending;
    gap_cnt_next  = gap_cnt;
    addr_next     = event_addr;
    done_next     = 1'b0;
    overflow_next = spike_overflow;

    case (state)
      IDLE: begin
        if (spike_valid) begin
          if (|spike_vec) state_next = EMIT;
          else            done_next  = 1'b1;
        end
      end
      EMIT: begin
        gap_cnt_next = CNT_W'(GAP_CYCLES - 2);
        state_next   = HOLD;
      end
      HOLD: begin
        if (gap_cnt == '0) begin
          if (|pending) begin
            state_next = EMIT;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          gap_cnt_next = gap_cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Pick and retire the index on entry to EMIT so the address is registered with the strobe
    if (state_next == EMIT) begin
      addr_next    = sel_idx;
      pending_next = src & ~(N_NEURONS'(1) << sel_idx);
    end

    if (spike_valid && !spike_ready) overflow_next = 1'b1;

    received_next = (state_next == EMIT);
    ready_next    = (state_next == IDLE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      pending        <= '0;
      gap_cnt        <= '0;
      event_addr     <= '0;
      event_received <= 1'b0;
      frame_done     <= 1'b0;
      spike_overflow <= 1'b0;
      spike_ready    <= 1'b1;
    end else begin
      state          <= state_next;
      pending        <= pending_next;
      gap_cnt        <= gap_cnt_next;
      event_addr     <= addr_next;
      event_received <= received_next;
      frame_done     <= done_next;
      spike_overflow <= overflow_next;
      spike_ready    <= ready_next;
    end
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Self-checking bench for spike_event_encoder (both ROUND_ROBIN_EN builds).
module tb_spike_event_encoder;

  localparam int N   = 16;
  localparam int GAP = 18;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] spike_vec;
  logic        spike_valid;
  logic        spike_ready;
  logic [3:0]  event_addr;
  logic        event_received;
  logic        frame_done;
  logic        spike_overflow;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int model_ptr = 0;

  typedef struct {
    logic [15:0] vec;
    int          n;
    int          done_c;
    int          first;
    int          last;
  } vec_t;

  spike_event_encoder #(.N_NEURONS(16), .ADDR_W(4), .GAP_CYCLES(18)) dut (
    .clock          (clock),
    .reset          (reset),
    .spike_vec      (spike_vec),
    .spike_valid    (spike_valid),
    .spike_ready    (spike_ready),
    .event_addr     (event_addr),
    .event_received (event_received),
    .frame_done     (frame_done),
    .spike_overflow (spike_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    spike_valid = 1'b0;
    spike_vec   = '0;
    step();
    reset     = 1'b0;
    model_ptr = 0;
  endtask

  // Expected emission order for one frame, from the selection rule
  function automatic void model_frame(input logic [15:0] v);
    logic [15:0] rem;
    int          idx;
    exp_q.delete();
    rem = v;
    while (rem != 16'h0) begin
`ifdef ROUND_ROBIN_EN
      idx = model_ptr;
      while (!rem[idx]) idx = (idx + 1) % N;
`else
      idx = 0;
      while (!rem[idx]) idx++;
`endif
      exp_q.push_back(idx);
      rem[idx]  = 1'b0;
      model_ptr = (idx + 1) % N;
    end
  endfunction

  // Offer v in the current cycle (cycle 0) and check the whole frame against the model
  task automatic run_frame(input logic [15:0] v, output int n_ev, output int done_c,
                           output int first_a, output int last_a);
    int cyc;
    int prev_rx;
    model_frame(v);
    n_ev = 0; done_c = -1; first_a = -1; last_a = -1; prev_rx = 0;
    spike_vec   = v;
    spike_valid = 1'b1;
    step();
    spike_valid = 1'b0;
    spike_vec   = '0;
    cyc = 1;
    while (cyc <= 1 + N * GAP + 4 && done_c < 0) begin
      if (event_received) begin
        check("no_back_to_back", prev_rx, 0);
        if (n_ev < exp_q.size()) begin
          check("event_addr", int'(event_addr), exp_q[n_ev]);
          check("event_cycle", cyc, 1 + n_ev * GAP);
        end else begin
          check("extra_event", n_ev, exp_q.size());
        end
        if (n_ev == 0) first_a = int'(event_addr);
        last_a = int'(event_addr);
        n_ev++;
      end
      if (frame_done) begin
        done_c = cyc;
        check("ready_at_done", int'(spike_ready), 1);
      end else begin
        check("ready_low_in_frame", int'(spike_ready), 0);
      end
      prev_rx = int'(event_received);
      if (done_c < 0) begin
        step();
        cyc++;
      end
    end
    check("event_count", n_ev, exp_q.size());
    check("event_count_popcount", n_ev, $countones(v));
    check("done_cycle", done_c, 1 + exp_q.size() * GAP);
  endtask

  initial begin
    vec_t tbl[5];
    int   n, d, f, l, cyc, done_c, extra, seen_done;
    int   ev[32];
    logic [15:0] v;

    tbl[0] = '{16'h0005, 2, 37, 0, 2};
    tbl[1] = '{16'h0000, 0, 1, -1, -1};
    tbl[2] = '{16'hFFFF, 16, 289, 0, 15};
    tbl[3] = '{16'h8000, 1, 19, 15, 15};
    tbl[4] = '{16'h0110, 2, 37, 4, 8};

    reset = 1'b1; spike_valid = 1'b0; spike_vec = '0;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_ready", int'(spike_ready), 1);
    check("rst_received", int'(event_received), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_addr", int'(event_addr), 0);
    check("rst_overflow", int'(spike_overflow), 0);

    // Directed vectors from a clean reset
    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_frame(tbl[i].vec, n, d, f, l);
      check("tbl_count", n, tbl[i].n);
      check("tbl_done", d, tbl[i].done_c);
      if (tbl[i].n > 0) begin
        check("tbl_first", f, tbl[i].first);
        check("tbl_last", l, tbl[i].last);
        check("tbl_addr_hold", int'(event_addr), tbl[i].last);
      end
    end

    // Overflow: second vector offered mid-frame is dropped
    do_reset();
    spike_vec = 16'h0003; spike_valid = 1'b1;
    step();
    spike_valid = 1'b0; spike_vec = '0;
    cyc = 1; n = 0; done_c = -1;
    while (cyc <= 60 && done_c < 0) begin
      spike_valid = (cyc == 5);
      spike_vec   = (cyc == 5) ? 16'h00F0 : 16'h0000;
      if (cyc == 5) check("ovf_before", int'(spike_overflow), 0);
      if (cyc == 6) check("ovf_set", int'(spike_overflow), 1);
      if (event_received) begin
        if (n < 32) ev[n] = int'(event_addr);
        n++;
      end
      if (frame_done) done_c = cyc;
      if (done_c < 0) begin
        step();
        cyc++;
      end
    end
    spike_valid = 1'b0; spike_vec = '0;
    check("ovf_count", n, 2);
    if (n >= 2) begin
      check("ovf_addr0", ev[0], 0);
      check("ovf_addr1", ev[1], 1);
    end
    check("ovf_done", done_c, 37);
    check("ovf_sticky", int'(spike_overflow), 1);

    // Reset mid-frame discards pending spikes and clears overflow
    do_reset();
    spike_vec = 16'h8001; spike_valid = 1'b1;
    step();
    n = 0; seen_done = 0;
    for (int c = 1; c <= 10; c++) begin
      spike_valid = (c == 3);
      spike_vec   = (c == 3) ? 16'hFFFF : 16'h0000;
      if (event_received) begin
        if (n < 32) ev[n] = int'(event_addr);
        n++;
      end
      if (frame_done) seen_done++;
      if (c == 4) check("mid_ovf_set", int'(spike_overflow), 1);
      reset = (c == 10);
      step();
    end
    reset = 1'b0; spike_valid = 1'b0; spike_vec = '0;
    model_ptr = 0;
    check("mid_count", n, 1);
    if (n >= 1) check("mid_addr0", ev[0], 0);
    check("mid_no_done", seen_done, 0);
    check("mid_rst_ready", int'(spike_ready), 1);
    check("mid_rst_rx", int'(event_received), 0);
    check("mid_rst_done", int'(frame_done), 0);
    check("mid_rst_addr", int'(event_addr), 0);
    check("mid_rst_ovf", int'(spike_overflow), 0);
    step();
    check("mid_c12_rx", int'(event_received), 0);
    check("mid_c12_done", int'(frame_done), 0);
    spike_vec = 16'h0002; spike_valid = 1'b1;
    step();
    spike_valid = 1'b0; spike_vec = '0;
    check("mid_c13_rx", int'(event_received), 1);
    check("mid_c13_addr", int'(event_addr), 1);
    cyc = 13; done_c = -1; extra = 0;
    while (cyc < 60 && done_c < 0) begin
      step();
      cyc++;
      if (event_received) extra++;
      if (frame_done) done_c = cyc;
    end
    check("mid_no_stale_event", extra, 0);
    check("mid_new_done", done_c, 31);

    // Ordering across frames; second frame offered while frame_done is high
    do_reset();
    run_frame(16'h0004, n, d, f, l);
    check("rr_first_frame_addr", f, 2);
    run_frame(16'h0009, n, d, f, l);
`ifdef ROUND_ROBIN_EN
    check("rr_order_first", f, 3);
    check("rr_order_last", l, 0);
`else
    check("prio_order_first", f, 0);
    check("prio_order_last", l, 3);
`endif

    // Randomized back-to-back frames against the model
    do_reset();
    for (int i = 0; i < 12; i++) begin
      v = 16'($urandom);
      if (i % 3 == 0) v = v & 16'($urandom) & 16'($urandom);
      if (i == 5) v = 16'h0000;
      run_frame(v, n, d, f, l);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
